// File: rtl/program_loader_if.sv
// Host byte stream handshake plus the SAP-1 programming bus, grouped as one bundle.
// master = loader side, slave = host/SAP-1 side.
interface program_loader_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] programmer_address;
   logic [7:0] programmer_data;
   logic       read_or_write;

   modport master (
      input  in_data, in_valid,
      output in_ready, programmer_address, programmer_data, read_or_write
   );

   modport slave (
      output in_data, in_valid,
      input  in_ready, programmer_address, programmer_data, read_or_write
   );
endinterface

// File: rtl/program_loader.sv
// Loads 16 host bytes into SAP-1 RAM (inverted data), clears the SAP-1, then supervises its run.
// Optional checksum byte after the program is compiled in with PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
   parameter int CLR_CYCLES  = 2,
   parameter int RUN_TIMEOUT = 255
) (
   input  logic                   CLK,
   input  logic                   CLR_bar,
   input  logic                   start,
   input  logic                   HLT_bar,
   program_loader_if.master       bus,
   output logic                   run_or_prog,
   output logic                   sap_clr,
   output logic                   busy,
   output logic                   done,
   output logic                   error
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_WRITE = 3'd2,
      S_CLEAR = 3'd3,
      S_RUN   = 3'd4,
      S_DONE  = 3'd5,
      S_FAIL  = 3'd6
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ,
      S_CHECK = 3'd7
`endif
   } state_t;

   state_t     r_state;
   state_t     w_next_state;
   logic [3:0] r_addr;
   logic [7:0] r_byte;
   logic [1:0] r_wr_phase;
   logic [3:0] r_clr_cnt;
   logic [7:0] r_run_cnt;
   logic       r_run_mode;
   logic       w_xfer;
   logic       w_start_ok;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0] r_sum;
   logic [7:0] w_sum_final;
   assign w_sum_final = r_sum + bus.in_data;
`endif

   assign w_xfer     = bus.in_valid & bus.in_ready;
   assign w_start_ok = start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_FAIL));

   always_ff @(posedge CLK or negedge CLR_bar) begin
      if (!CLR_bar) r_state <= S_IDLE;
      else          r_state <= w_next_state;
   end

   // WRITE runs three phases: setup, strobe, hold, so the bus is stable around the strobe.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_FAIL: if (start) w_next_state = S_LOAD;
         S_LOAD:  if (w_xfer) w_next_state = S_WRITE;
         S_WRITE: begin
            if (r_wr_phase == 2'd2) begin
               if (r_addr != 4'd15) w_next_state = S_LOAD;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               else                 w_next_state = S_CHECK;
`else
               else                 w_next_state = S_CLEAR;
`endif
            end
         end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         S_CHECK: if (w_xfer) w_next_state = (w_sum_final == 8'h00) ? S_CLEAR : S_FAIL;
`endif
         S_CLEAR: if (r_clr_cnt == 4'(CLR_CYCLES - 1)) w_next_state = S_RUN;
         S_RUN: begin
            if (!HLT_bar)                               w_next_state = S_DONE;
            else if (r_run_cnt == 8'(RUN_TIMEOUT - 1))  w_next_state = S_FAIL;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready      = (r_state == S_LOAD);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      if (r_state == S_CHECK) bus.in_ready = 1'b1;
`endif
      bus.read_or_write = !((r_state == S_WRITE) && (r_wr_phase == 2'd1));
      sap_clr           = (r_state == S_CLEAR);
      busy              = !((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_FAIL));
      done              = (r_state == S_DONE);
      error             = (r_state == S_FAIL);
      run_or_prog       = r_run_mode;
   end

   assign bus.programmer_address = r_addr;
   assign bus.programmer_data    = ~r_byte;

   always_ff @(posedge CLK or negedge CLR_bar) begin
      if (!CLR_bar) begin
         r_addr     <= '0;
         r_byte     <= '0;
         r_wr_phase <= '0;
         r_clr_cnt  <= '0;
         r_run_cnt  <= '0;
         r_run_mode <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         r_sum      <= '0;
`endif
      end else begin
         if (w_start_ok) begin
            r_addr     <= '0;
            r_run_mode <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            r_sum      <= '0;
`endif
         end
         if ((r_state == S_LOAD) && w_xfer) begin
            r_byte <= bus.in_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            r_sum  <= r_sum + bus.in_data;
`endif
         end
         if (r_state == S_WRITE) begin
            r_wr_phase <= (r_wr_phase == 2'd2) ? 2'd0 : r_wr_phase + 2'd1;
            if (r_wr_phase == 2'd2) r_addr <= r_addr + 4'd1;
         end
         if (r_state == S_CLEAR)
            r_clr_cnt <= (w_next_state == S_CLEAR) ? r_clr_cnt + 4'd1 : 4'd0;
         if (r_state == S_RUN)
            r_run_cnt <= (w_next_state == S_RUN) ? r_run_cnt + 8'd1 : 8'd0;
         // Run mode is latched on entry to CLEAR so a checksum failure leaves it in program mode.
         if ((w_next_state == S_CLEAR) && (r_state != S_CLEAR))
            r_run_mode <= 1'b1;
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader; also covers the checksum build
// when PROGRAM_LOADER_CHECKSUM_EN is defined.
module tb_program_loader;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   localparam int NBYTES = 17;
`else
   localparam int NBYTES = 16;
`endif

   logic CLK = 1'b0;
   logic CLR_bar = 1'b0;
   logic start = 1'b0;
   logic HLT_bar = 1'b1;
   logic run_or_prog, sap_clr, busy, done, error;

   program_loader_if bus ();

   program_loader #(.CLR_CYCLES(2), .RUN_TIMEOUT(255)) dut (
      .CLK         (CLK),
      .CLR_bar     (CLR_bar),
      .start       (start),
      .HLT_bar     (HLT_bar),
      .bus         (bus),
      .run_or_prog (run_or_prog),
      .sap_clr     (sap_clr),
      .busy        (busy),
      .done        (done),
      .error       (error)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] tx_bytes [0:16];

   // Write-pulse monitor: records each strobe with the bus seen one cycle before and after.
   logic [3:0] wr_addr [$];
   logic [7:0] wr_data [$];
   bit         wr_ok   [$];
   bit         wr_rop  [$];
   int         clr_count = 0;
   logic       p1_rw = 1'b1, p2_rw = 1'b1, p1_rop = 1'b0;
   logic [3:0] p1_addr = '0, p2_addr = '0;
   logic [7:0] p1_data = '0, p2_data = '0;

   always @(negedge CLK) begin
      if (p1_rw == 1'b0) begin
         wr_addr.push_back(p1_addr);
         wr_data.push_back(p1_data);
         wr_rop.push_back(p1_rop);
         wr_ok.push_back(p2_rw && bus.read_or_write &&
                         (p2_addr == p1_addr) && (bus.programmer_address == p1_addr) &&
                         (p2_data == p1_data) && (bus.programmer_data == p1_data));
      end
      if (sap_clr) clr_count = clr_count + 1;
      p2_rw   = p1_rw;
      p2_addr = p1_addr;
      p2_data = p1_data;
      p1_rw   = bus.read_or_write;
      p1_addr = bus.programmer_address;
      p1_data = bus.programmer_data;
      p1_rop  = run_or_prog;
   end

   initial begin
      bus.in_data  = '0;
      bus.in_valid = 1'b0;
   end

   task automatic pulse_start();
      @(negedge CLK);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
   endtask

   task automatic send_bytes(input bit rnd, output bit timed_out);
      int idx;
      idx = 0;
      for (int cyc = 0; cyc < 2000 && idx < NBYTES; cyc++) begin
         bus.in_data  = tx_bytes[idx];
         bus.in_valid = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
         if (bus.in_valid && bus.in_ready) idx++;
         @(negedge CLK);
      end
      bus.in_valid = 1'b0;
      timed_out = (idx < NBYTES);
   endtask

   task automatic wait_sap_clr_rise(output bit timed_out);
      timed_out = 1'b1;
      for (int c = 0; c < 200; c++) begin
         if (sap_clr) begin
            timed_out = 1'b0;
            break;
         end
         @(negedge CLK);
      end
   endtask

   task automatic test_reset();
      CLR_bar = 1'b0;
      #12;
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
      n_checks++; if (bus.programmer_address !== 4'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", bus.programmer_address); end
      n_checks++; if (bus.programmer_data !== 8'hFF) begin n_fail++; $display("FAIL reset_data got %h want ff", bus.programmer_data); end
      n_checks++; if (bus.read_or_write !== 1'b1) begin n_fail++; $display("FAIL reset_rw got %b want 1", bus.read_or_write); end
      n_checks++; if (run_or_prog !== 1'b0) begin n_fail++; $display("FAIL reset_rop got %b want 0", run_or_prog); end
      n_checks++; if (sap_clr !== 1'b0) begin n_fail++; $display("FAIL reset_sap_clr got %b want 0", sap_clr); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
      n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b want 0", error); end
      @(negedge CLK);
      CLR_bar = 1'b1;
      $display("test_reset: reset values checked");
   endtask

   task automatic test_load_basic();
      int  base, clr_len;
      bit  to, rop_bad;
      logic [7:0] e;
      for (int i = 0; i < 16; i++) tx_bytes[i] = 8'(i);
      tx_bytes[16] = 8'h88;
      base = wr_addr.size();
      HLT_bar = 1'b1;
      pulse_start();
      n_checks++; if (busy !== 1'b1 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL start_to_load busy=%b in_ready=%b want 1/1", busy, bus.in_ready); end
      send_bytes(1'b0, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL basic_send timed out want all bytes accepted"); end
      wait_sap_clr_rise(to);
      n_checks++; if (to) begin n_fail++; $display("FAIL basic_clear_rise sap_clr=%b want 1", sap_clr); end
      clr_len = 0;
      rop_bad = 1'b0;
      for (int c = 0; c < 50 && sap_clr; c++) begin
         if (run_or_prog !== 1'b1) rop_bad = 1'b1;
         clr_len++;
         @(negedge CLK);
      end
      n_checks++; if (clr_len != 2) begin n_fail++; $display("FAIL basic_clear_len got %0d want 2", clr_len); end
      n_checks++; if (rop_bad || run_or_prog !== 1'b1) begin n_fail++; $display("FAIL basic_clear_rop got %b want 1", run_or_prog); end
      n_checks++;
      if (wr_addr.size() - base != 16) begin
         n_fail++; $display("FAIL basic_write_count got %0d want 16", wr_addr.size() - base);
      end else begin
         for (int i = 0; i < 16; i++) begin
            e = ~tx_bytes[i];
            n_checks++;
            if (wr_addr[base+i] !== 4'(i) || wr_data[base+i] !== e || !wr_ok[base+i]) begin
               n_fail++;
               $display("FAIL basic_write%0d got addr=%h data=%h stable=%0d want addr=%h data=%h stable=1",
                        i, wr_addr[base+i], wr_data[base+i], wr_ok[base+i], 4'(i), e);
            end
         end
      end
      // Now on run cycle 0; halt on run cycle 10.
      for (int k = 0; k < 10; k++) @(negedge CLK);
      n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL run_cycle10 busy=%b done=%b want 1/0", busy, done); end
      HLT_bar = 1'b0;
      @(negedge CLK);
      HLT_bar = 1'b1;
      n_checks++; if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL halt_done done=%b busy=%b error=%b want 1/0/0", done, busy, error); end
      n_checks++; if (run_or_prog !== 1'b1) begin n_fail++; $display("FAIL done_rop got %b want 1", run_or_prog); end
      $display("test_load_basic: 16 writes, clear length %0d, done=%b", clr_len, done);
   endtask

   task automatic test_random_hlt_timeout();
      int  base, run_n;
      bit  to;
      logic [7:0] e;
      for (int i = 0; i < 16; i++) tx_bytes[i] = 8'hA0 + 8'(i);
      tx_bytes[16] = 8'h88;
      base = wr_addr.size();
      HLT_bar = 1'b0;
      pulse_start();
      n_checks++; if (run_or_prog !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL restart_from_done rop=%b done=%b want 0/0", run_or_prog, done); end
      send_bytes(1'b1, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL random_send timed out want all bytes accepted"); end
      n_checks++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL hlt_in_load done=%b busy=%b want 0/1", done, busy); end
      HLT_bar = 1'b1;
      wait_sap_clr_rise(to);
      n_checks++; if (to) begin n_fail++; $display("FAIL random_clear_rise sap_clr=%b want 1", sap_clr); end
      n_checks++;
      if (wr_addr.size() - base != 16) begin
         n_fail++; $display("FAIL random_write_count got %0d want 16", wr_addr.size() - base);
      end else begin
         n_checks++; if (wr_rop[base] !== 1'b0) begin n_fail++; $display("FAIL first_write_rop got %b want 0", wr_rop[base]); end
         for (int i = 0; i < 16; i++) begin
            e = ~tx_bytes[i];
            n_checks++;
            if (wr_addr[base+i] !== 4'(i) || wr_data[base+i] !== e || !wr_ok[base+i]) begin
               n_fail++;
               $display("FAIL random_write%0d got addr=%h data=%h stable=%0d want addr=%h data=%h stable=1",
                        i, wr_addr[base+i], wr_data[base+i], wr_ok[base+i], 4'(i), e);
            end
         end
      end
      for (int c = 0; c < 50 && sap_clr; c++) @(negedge CLK);
      run_n = 0;
      for (int c = 0; c < 400; c++) begin
         if (error) break;
         if (busy) run_n++;
         @(negedge CLK);
      end
      n_checks++; if (run_n != 255) begin n_fail++; $display("FAIL timeout_cycles got %0d want 255", run_n); end
      n_checks++; if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL timeout_flags error=%b done=%b busy=%b want 1/0/0", error, done, busy); end
      n_checks++; if (run_or_prog !== 1'b1) begin n_fail++; $display("FAIL fail_rop got %b want 1", run_or_prog); end
      $display("test_random_hlt_timeout: %0d run cycles before error=%b", run_n, error);
   endtask

   task automatic test_reset_midload();
      int  base, idx;
      bit  to;
      logic [7:0] e;
      for (int i = 0; i < 16; i++) tx_bytes[i] = 8'h10 + 8'(i);
      tx_bytes[16] = 8'h88;
      base = wr_addr.size();
      pulse_start();
      n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL restart_from_fail error=%b want 0", error); end
      idx = 0;
      to = 1'b1;
      for (int c = 0; c < 300; c++) begin
         bus.in_data  = tx_bytes[idx];
         bus.in_valid = 1'b1;
         if (bus.in_ready) idx++;
         @(negedge CLK);
         if (wr_addr.size() - base >= 7) begin
            to = 1'b0;
            break;
         end
      end
      n_checks++; if (to) begin n_fail++; $display("FAIL midload_progress writes=%0d want 7", wr_addr.size() - base); end
      CLR_bar = 1'b0;
      #1;
      n_checks++; if (bus.programmer_address !== 4'h0 || bus.programmer_data !== 8'hFF) begin n_fail++; $display("FAIL midreset_bus addr=%h data=%h want 0/ff", bus.programmer_address, bus.programmer_data); end
      n_checks++; if (bus.read_or_write !== 1'b1 || bus.in_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midreset_ctrl rw=%b in_ready=%b busy=%b want 1/0/0", bus.read_or_write, bus.in_ready, busy); end
      n_checks++; if (sap_clr !== 1'b0 || run_or_prog !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL midreset_flags sap_clr=%b rop=%b done=%b error=%b want 0/0/0/0", sap_clr, run_or_prog, done, error); end
      bus.in_valid = 1'b0;
      @(negedge CLK);
      CLR_bar = 1'b1;
      @(negedge CLK);
      base = wr_addr.size();
      pulse_start();
      send_bytes(1'b0, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL reload_send timed out want all bytes accepted"); end
      wait_sap_clr_rise(to);
      HLT_bar = 1'b0;
      n_checks++;
      if (wr_addr.size() - base != 16) begin
         n_fail++; $display("FAIL reload_write_count got %0d want 16", wr_addr.size() - base);
      end else begin
         for (int i = 0; i < 16; i++) begin
            e = ~tx_bytes[i];
            n_checks++;
            if (wr_addr[base+i] !== 4'(i) || wr_data[base+i] !== e) begin
               n_fail++;
               $display("FAIL reload_write%0d got addr=%h data=%h want addr=%h data=%h",
                        i, wr_addr[base+i], wr_data[base+i], 4'(i), e);
            end
         end
      end
      to = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (done) begin
            to = 1'b0;
            break;
         end
         @(negedge CLK);
      end
      HLT_bar = 1'b1;
      n_checks++; if (to) begin n_fail++; $display("FAIL reload_done done=%b want 1", done); end
      $display("test_reset_midload: reload from address 0, done=%b", done);
   endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      int clr_before;
      bit to;
      for (int i = 0; i < 16; i++) tx_bytes[i] = 8'h01;
      tx_bytes[16] = 8'hF0;
      pulse_start();
      send_bytes(1'b0, to);
      wait_sap_clr_rise(to);
      n_checks++; if (to) begin n_fail++; $display("FAIL checksum_good sap_clr=%b want 1", sap_clr); end
      HLT_bar = 1'b0;
      for (int c = 0; c < 20 && !done; c++) @(negedge CLK);
      HLT_bar = 1'b1;
      tx_bytes[16] = 8'hF1;
      clr_before = clr_count;
      pulse_start();
      send_bytes(1'b0, to);
      @(negedge CLK);
      n_checks++; if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL checksum_bad error=%b busy=%b done=%b want 1/0/0", error, busy, done); end
      n_checks++; if (run_or_prog !== 1'b0) begin n_fail++; $display("FAIL checksum_bad_rop got %b want 0", run_or_prog); end
      n_checks++; if (clr_count != clr_before) begin n_fail++; $display("FAIL checksum_bad_sap_clr cycles=%0d want 0", clr_count - clr_before); end
      $display("test_checksum: good sum cleared, bad sum error=%b", error);
   endtask
`endif

   initial begin
      test_reset();
      test_load_basic();
      test_random_hlt_timeout();
      test_reset_midload();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter CLR_CYCLES, default 2: cycles sap_clr is held high before the run phase (legal 1-15).
REQ-002 SHALL have parameter RUN_TIMEOUT, default 255: maximum run-phase cycles before timeout (legal 1-255).
REQ-003 SHALL have port CLK, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port CLR_bar, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: request to begin a load sequence.
REQ-006 SHALL have port in_data, input, 8: program byte from the host.
REQ-007 SHALL have port in_valid, input, 1: in_data is valid.
REQ-008 SHALL have port in_ready, output, 1: loader accepts a byte this cycle.
REQ-009 SHALL have port programmer_address, output, 4: SAP-1 programming address.
REQ-010 SHALL have port programmer_data, output, 8: SAP-1 programming data, always the bitwise NOT of the stored byte.
REQ-011 SHALL have port read_or_write, output, 1: 0 = write RAM, 1 = read.
REQ-012 SHALL have port run_or_prog, output, 1: 0 = program mode, 1 = run mode.
REQ-013 SHALL have port sap_clr, output, 1: active-high clear to the SAP-1.
REQ-014 SHALL have port HLT_bar, input, 1: SAP-1 halt, active-low.
REQ-015 SHALL have ports busy, done and error, outputs, 1 each: status flags.

Function
REQ-016 SHALL implement states IDLE, LOAD, WRITE, CHECK, CLEAR, RUN, DONE and FAIL.
REQ-017 IDLE: start=1 SHALL clear the address, checksum, done and error, and go to LOAD next cycle; busy=1 in every state except IDLE, DONE and FAIL.
REQ-018 LOAD: in_ready=1; a transfer SHALL occur only when in_valid=1 and in_ready=1, latching in_data, driving programmer_data=~in_data, and going to WRITE.
REQ-019 in_ready SHALL be 0 in every state other than LOAD (and CHECK when enabled); in_valid SHALL be ignored there.
REQ-020 WRITE: read_or_write=0 for exactly one cycle, with programmer_address and programmer_data stable from the cycle before through the cycle after.
REQ-021 After WRITE, the address SHALL increment (4-bit), returning to LOAD if the written address was below 15, otherwise going to CHECK (macro defined) or CLEAR.
REQ-022 CLEAR: run_or_prog=1 and sap_clr=1 for exactly CLR_CYCLES cycles, then sap_clr=0 and go to RUN.
REQ-023 RUN: an 8-bit cycle counter SHALL start at 0; HLT_bar=0 SHALL go to DONE; reaching RUN_TIMEOUT with HLT_bar=1 SHALL go to FAIL.
REQ-024 HLT_bar SHALL be ignored in all states except RUN.
REQ-025 DONE SHALL set done=1; FAIL SHALL set error=1; both flags SHALL hold until the next accepted start.
REQ-026 run_or_prog SHALL stay 1 in DONE and FAIL.
REQ-027 start SHALL be accepted in IDLE, DONE and FAIL, and ignored while busy=1.
REQ-028 When start is accepted in DONE or FAIL, run_or_prog SHALL return to 0 before the first write.

Reset
REQ-029 CLR_BAR=0 SHALL force the following values asynchronously, from any state, mid-transfer included: state IDLE, programmer_address 0, programmer_data 8'hFF, read_or_write 1, run_or_prog 0, sap_clr 0, in_ready 0, busy 0, done 0, error 0, counters 0.
REQ-030 A write interrupted by reset SHALL NOT be retried after release.

Configuration
REQ-031 SHALL support macro PROGRAM_LOADER_CHECKSUM_EN to compile the checksum check in or out.
REQ-032 With PROGRAM_LOADER_CHECKSUM_EN defined, CHECK SHALL accept one extra byte via the handshake.
REQ-033 CHECK SHALL go to CLEAR if the 8-bit modulo-256 sum of the 16 bytes plus the extra byte is 8'h00, otherwise go to FAIL with run_or_prog left at 0.
REQ-034 Without PROGRAM_LOADER_CHECKSUM_EN, the CHECK state and the sum logic SHALL be absent, and address 15 SHALL go straight to CLEAR.

Verification
REQ-035 Test: reset, start, 16 bytes 0x00-0x0F with in_valid held -> 16 one-cycle write pulses, address n carries data ~n, then sap_clr high for 2 cycles and run_or_prog=1.
REQ-036 Test: in_valid toggled randomly during LOAD -> no byte lost or duplicated, and each write pulse is preceded by a stable address and data cycle.
REQ-037 Test: HLT_bar forced to 0 during LOAD -> no effect; HLT_bar=0 on run cycle 10 -> done=1 next cycle and busy=0.
REQ-038 Test: HLT_bar held at 1 -> after 255 run cycles error=1, FAIL entered, done=0.
REQ-039 Test: CLR_bar pulsed low after 7 writes -> all outputs return to their reset values immediately; a new start reloads from address 0.
REQ-040 Test (PROGRAM_LOADER_CHECKSUM_EN): bytes 0x01 x16 with checksum 0xF0 -> CLEAR entered; with checksum 0xF1 -> FAIL, error=1, sap_clr never asserted.
